// File: rtl/filter_test_sequencer_if.sv
// Control, readout and generator-test signals of the filter test sequencer.
// master = control/readout side, slave = sequencer.
interface filter_test_sequencer_if #(
  parameter int SIZE_DELAY       = 8,
  parameter int SIZE_FILTER_DATA = 16,
  parameter int NUM_STEPS        = 4
);
  localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  logic                        cfg_we;
  logic [STEP_W-1:0]           cfg_addr;
  logic                        cfg_overlay;
  logic                        cfg_rate;
  logic [SIZE_DELAY-1:0]       cfg_delay;
  logic [STEP_W-1:0]           cfg_last;
  logic                        start;
  logic                        abort;
  logic [SIZE_FILTER_DATA-1:0] filter_data;
  logic                        test_overlay;
  logic                        test_rate;
  logic [SIZE_DELAY-1:0]       test_delay;
  logic                        gen_reset;
  logic                        busy;
  logic                        done;
  logic                        result_valid;
  logic [STEP_W-1:0]           result_step;
  logic [SIZE_FILTER_DATA-1:0] result_peak;

  modport master (
    output cfg_we, cfg_addr, cfg_overlay, cfg_rate, cfg_delay, cfg_last,
    output start, abort, filter_data,
    input  test_overlay, test_rate, test_delay, gen_reset,
    input  busy, done, result_valid, result_step, result_peak
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_overlay, cfg_rate, cfg_delay, cfg_last,
    input  start, abort, filter_data,
    output test_overlay, test_rate, test_delay, gen_reset,
    output busy, done, result_valid, result_step, result_peak
  );
endinterface

// File: rtl/filter_test_sequencer.sv
// Steps the signal generator through a programmed table and reports the signed peak per step.
// SETTLE+DWELL+2 cycles per step; no backpressure, start/cfg_we are ignored while busy.
module filter_test_sequencer #(
  parameter int SIZE_DELAY       = 8,
  parameter int SIZE_FILTER_DATA = 16,
  parameter int NUM_STEPS        = 4,
  parameter int SETTLE           = 16,
  parameter int DWELL            = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  filter_test_sequencer_if.slave  bus
);
  localparam int STEP_W  = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int CNT_MAX = (SETTLE > DWELL) ? SETTLE : DWELL;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [SIZE_FILTER_DATA-1:0] MOST_NEG = {1'b1, {(SIZE_FILTER_DATA-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_MEASURE, S_REPORT, S_DONE
  } state_t;

  typedef struct packed {
    logic                  overlay;
    logic                  rate;
    logic [SIZE_DELAY-1:0] delay;
  } entry_t;

  state_t      state, state_n;
  logic [STEP_W-1:0] step, step_n, last_q, last_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  entry_t      tbl [NUM_STEPS];
  entry_t      wr_entry, load_entry, test_q;
  logic        wr_en;
  logic        gen_reset_q;
  logic signed [SIZE_FILTER_DATA-1:0] fdata, peak, peak_n, res_peak;
  logic [STEP_W-1:0] res_step;

  assign fdata    = bus.filter_data;
  assign wr_en    = (state == S_IDLE) && bus.cfg_we;
  assign wr_entry = '{overlay: bus.cfg_overlay, rate: bus.cfg_rate, delay: bus.cfg_delay};

  always_comb begin
    state_n = state;
    step_n  = step;
    last_n  = last_q;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_n = S_LOAD;
          step_n  = '0;
          last_n  = bus.cfg_last;
        end
      end
      S_LOAD: begin
        state_n = S_SETTLE;
        cnt_n   = '0;
      end
      S_SETTLE: begin
        if (cnt == CNT_W'(SETTLE - 1)) begin
          state_n = S_MEASURE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_MEASURE: begin
        if (cnt == CNT_W'(DWELL - 1)) begin
          state_n = S_REPORT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_REPORT: begin
        if (step == last_q) begin
          state_n = S_DONE;
        end else begin
          state_n = S_LOAD;
          step_n  = step + STEP_W'(1);
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (bus.abort && (state == S_LOAD || state == S_SETTLE ||
                      state == S_MEASURE || state == S_REPORT)) begin
      state_n = S_IDLE;
    end
  end

  // A write landing on the same edge as start must be visible to the first LOAD.
  always_comb begin
    load_entry = tbl[step_n];
    if (wr_en && bus.cfg_addr == step_n) load_entry = wr_entry;
    peak_n = peak;
    if (state == S_MEASURE && fdata > peak) peak_n = fdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      step        <= '0;
      last_q      <= '0;
      cnt         <= '0;
      test_q      <= '0;
      gen_reset_q <= 1'b1;
      peak        <= '0;
      res_step    <= '0;
      res_peak    <= '0;
      for (int i = 0; i < NUM_STEPS; i++) tbl[i] <= '0;
    end else begin
      state       <= state_n;
      step        <= step_n;
      last_q      <= last_n;
      cnt         <= cnt_n;
      gen_reset_q <= (state_n != S_LOAD);
      if (wr_en) tbl[bus.cfg_addr] <= wr_entry;
      if (state_n == S_LOAD) begin
        test_q <= load_entry;
        peak   <= MOST_NEG;
      end else begin
        if (state_n == S_IDLE) test_q <= '0;
        peak <= peak_n;
      end
      if (state == S_MEASURE && state_n == S_REPORT) begin
        res_step <= step;
        res_peak <= peak_n;
      end
    end
  end

  assign bus.test_overlay = test_q.overlay;
  assign bus.test_rate    = test_q.rate;
  assign bus.test_delay   = test_q.delay;
  assign bus.gen_reset    = gen_reset_q;
  assign bus.busy         = (state == S_LOAD) || (state == S_SETTLE) ||
                            (state == S_MEASURE) || (state == S_REPORT);
  assign bus.done         = (state == S_DONE);
  assign bus.result_valid = (state == S_REPORT);
  assign bus.result_step  = res_step;
  assign bus.result_peak  = res_peak;
endmodule

// File: doc/filter_test_sequencer.md
Name: filter_test_sequencer

Overview:
- Drives the test controls of the exponential signal generator (overlay, rate, delay) through a programmed table of test steps.
- For each step: restarts the generator, waits a settle interval, then measures the signed peak of one selected filter output over a dwell window and reports it.
- Sits beside the filter top level, between the control/readout logic and the exp_sig_gen / v*_filter chain.
- Replaces static test_overlay/test_rate/test_delay inputs with an automated sweep.

Parameters:
- SIZE_DELAY, 8: width of test_delay and of each table delay field.
- SIZE_FILTER_DATA, 16: width of the measured filter output, two's complement.
- NUM_STEPS, 4: table depth, power of two. STEP_W = clog2(NUM_STEPS).
- SETTLE, 16: cycles ignored after generator restart, ≥1.
- DWELL, 1024: measurement cycles per step, ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  STEP_W  table entry index.
- cfg_overlay  in  1  overlay bit for the entry.
- cfg_rate  in  1  rate bit for the entry.
- cfg_delay  in  SIZE_DELAY  delay value for the entry.
- cfg_last  in  STEP_W  index of the last step to run; sampled when start is accepted.
- start  in  1  run request, level or pulse.
- abort  in  1  stop the sweep immediately.
- filter_data  in  SIZE_FILTER_DATA  measured filter output, signed.
- test_overlay  out  1  to generator overlay input, registered.
- test_rate  out  1  to generator rate input, registered.
- test_delay  out  SIZE_DELAY  to generator delay input, registered.
- gen_reset  out  1  active-low generator restart, registered.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at normal completion.
- result_valid  out  1  one-cycle pulse, per-step result ready.
- result_step  out  STEP_W  step index of the current result.
- result_peak  out  SIZE_FILTER_DATA  signed maximum of filter_data over the dwell window.

Behaviour:
- Reset (reset=0 at an edge) sets:
  - state to IDLE;
  - all outputs to 0, except gen_reset=1;
  - table entries to 0;
  - counters to 0.
  Reset mid-sweep takes effect at that edge: no done, no result_valid.
- Table writes:
  - cfg_we in IDLE writes entry cfg_addr at the edge.
  - cfg_we while busy is ignored; the table is never modified during a sweep.
- FSM states are IDLE, LOAD, SETTLE, MEASURE, REPORT, DONE.
- IDLE: busy=0. If start=1 and abort=0 at an edge:
  - latch cfg_last;
  - set step=0;
  - go to LOAD.
- LOAD, exactly 1 cycle: busy=1, gen_reset=0.
  - test_* take the values of entry[step] on the edge entering LOAD and hold them until the next LOAD or IDLE.
  - peak register is set to the most negative value (0x8000 for 16 bits).
  - Then go to SETTLE.
- SETTLE: gen_reset=1. Lasts exactly SETTLE cycles; filter_data is ignored. Then go to MEASURE.
- MEASURE: lasts exactly DWELL cycles.
  - Each cycle: peak <= signed max(peak, filter_data).
  - The comparison is signed. Ties keep the old value, which is indistinguishable.
- REPORT, 1 cycle: result_valid=1, result_step=step, result_peak=final peak including the last MEASURE sample.
  - result_step and result_peak hold until the next REPORT.
  - If step==latched cfg_last, go to DONE; else step<=step+1 and go to LOAD.
- DONE, 1 cycle: done=1, busy=0, test_* hold their last values. Then go to IDLE.
- Cycles per step are exactly SETTLE+DWELL+2.
- Latency:
  - start accepted at edge k → first result_valid in cycle k+SETTLE+DWELL+1 (LOAD is cycle k).
  - done follows the last REPORT by 1 cycle.
- abort=1 at any edge in LOAD..REPORT:
  - go to IDLE at that edge;
  - busy=0, gen_reset=1, test_* cleared to 0;
  - no result_valid, no done.
  - abort in IDLE or DONE has no effect, apart from blocking start in IDLE.
- start while busy or in DONE is ignored. A start held high in IDLE after DONE starts a new sweep.
- cfg_last=0 runs exactly one step. cfg_last=NUM_STEPS-1 runs the full table. The step counter never wraps.
- Simultaneous start and cfg_we in IDLE: the write completes and the sweep uses the new entry.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles, then release → test_*=0, gen_reset=1, busy=0, done=0, result_valid=0. Table reads back 0 via a sweep with cfg_last=0 → test_delay=0.
- Single step, with SETTLE=4, DWELL=8: write entry0 = {overlay=1, rate=0, delay=0x2A}, cfg_last=0, start at edge k.
  - LOAD at cycle k: gen_reset=0; from k, test_overlay=1 and test_delay=0x2A.
  - filter_data = -5,3,100,7,-20,99,0,1 during MEASURE → result_valid at cycle k+13 with result_peak=100, result_step=0.
  - done at k+14, busy low from k+14.
- All-negative data: filter_data stays at -300 for the whole dwell → result_peak=-300, confirming signed compare and the most-negative initial value.
- Full sweep, cfg_last=3, four distinct entries → exactly 4 result_valid pulses spaced 14 cycles apart, result_step 0,1,2,3, test_* changing in each LOAD, then one done.
- Abort: assert abort during MEASURE of step 1 → next cycle busy=0, test_*=0, no further result_valid, no done. A subsequent start runs normally from step 0.
- Ignored inputs: pulse start and cfg_we (addr 0, delay 0xFF) mid-sweep → sweep timing is unchanged and entry0 is not modified; a following sweep still uses 0x2A.
